// File: rtl/ro_puf_response_gen_if.sv
// RO PUF side-band: challenge/enable out to the PUF, count/completion back.
// Combinational bundle; no latency of its own, no backpressure beyond puf_completed.
interface ro_puf_response_gen_if;
  logic [9:0]  puf_challenge;
  logic        puf_en;
  logic [31:0] puf_count;
  logic        puf_completed;

  modport master (output puf_challenge, output puf_en,
                  input  puf_count,     input  puf_completed);
  modport slave  (input  puf_challenge, input  puf_en,
                  output puf_count,     output puf_completed);
endinterface

// File: rtl/ro_puf_response_gen.sv
// Builds a RESP_BITS response by comparing RO k against RO k+1; start sampled only when idle.
// Latency 1 + RESP_BITS*(2*(1+Tm)+1) + 1 cycles; PUF completion acts as the only backpressure.
module ro_puf_response_gen #(
  parameter int RESP_BITS = 8,
  parameter int TIMEOUT   = 600_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [5:0]               cfg_i,
  ro_puf_response_gen_if.master    puf,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [RESP_BITS-1:0]     response_o,
  output logic                     tie_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR_A, S_MEAS_A, S_CLR_B, S_MEAS_B, S_CMP, S_DONE
  } state_t;

  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(RESP_BITS - 1);

  state_t                 state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic [5:0]             cfg_q, cfg_d;
  logic [31:0]            count_a_q, count_a_d;
  logic [31:0]            count_b_q, count_b_d;
  logic [19:0]            timer_q, timer_d;
  logic [7:0]             resp_q, resp_d;
  logic                   tie_q, tie_d;
  logic                   err_q, err_d;
  logic [RESP_BITS-1:0]   resp_out_q, resp_out_d;
  logic                   tie_out_q, tie_out_d;
  logic                   err_out_q, err_out_d;
  logic [3:0]             ro_idx;

  // Index is a pure function of state and k, so it cannot move during CLR_x/MEAS_x.
  assign ro_idx = (state_q == S_CLR_B || state_q == S_MEAS_B) ? ({1'b0, k_q} + 4'd1)
                                                               : {1'b0, k_q};

  assign puf.puf_challenge = {ro_idx, cfg_q};
  assign puf.puf_en        = (state_q == S_MEAS_A) || (state_q == S_MEAS_B);
  assign busy_o            = (state_q != S_IDLE);
  assign done_o            = (state_q == S_DONE);
  assign response_o        = resp_out_q;
  assign tie_o             = tie_out_q;
  assign error_o           = err_out_q;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cfg_d      = cfg_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
    timer_d    = timer_q;
    resp_d     = resp_q;
    tie_d      = tie_q;
    err_d      = err_q;
    resp_out_d = resp_out_q;
    tie_out_d  = tie_out_q;
    err_out_d  = err_out_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cfg_d     = cfg_i;
          k_d       = 3'd0;
          err_d     = 1'b0;
          tie_d     = 1'b0;
          resp_d    = 8'd0;
          err_out_d = 1'b0;
          state_d   = S_CLR_A;
        end
      end
      S_CLR_A: begin
        timer_d = 20'd0;
        state_d = S_MEAS_A;
      end
      S_MEAS_A: begin
        if (puf.puf_completed) begin
          count_a_d = puf.puf_count;
          state_d   = S_CLR_B;
        end else if (timer_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      S_CLR_B: begin
        timer_d = 20'd0;
        state_d = S_MEAS_B;
      end
      S_MEAS_B: begin
        if (puf.puf_completed) begin
          count_b_d = puf.puf_count;
          state_d   = S_CMP;
        end else if (timer_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      S_CMP: begin
        resp_d[k_q] = (count_a_q > count_b_q);
        tie_d       = tie_q | (count_a_q == count_b_q);
        if (k_q == LAST_BIT) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = S_CLR_A;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Publish on entry to DONE so the outputs are already valid during the done pulse.
    if (state_d == S_DONE && state_q != S_DONE) begin
      resp_out_d = err_d ? '0 : resp_d[RESP_BITS-1:0];
      tie_out_d  = tie_d;
      err_out_d  = err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= 3'd0;
      cfg_q      <= 6'd0;
      count_a_q  <= 32'd0;
      count_b_q  <= 32'd0;
      timer_q    <= 20'd0;
      resp_q     <= 8'd0;
      tie_q      <= 1'b0;
      err_q      <= 1'b0;
      resp_out_q <= '0;
      tie_out_q  <= 1'b0;
      err_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cfg_q      <= cfg_d;
      count_a_q  <= count_a_d;
      count_b_q  <= count_b_d;
      timer_q    <= timer_d;
      resp_q     <= resp_d;
      tie_q      <= tie_d;
      err_q      <= err_d;
      resp_out_q <= resp_out_d;
      tie_out_q  <= tie_out_d;
      err_out_q  <= err_out_d;
    end
  end

endmodule

// File: tb/tb_ro_puf_response_gen.sv
// Directed bench for ro_puf_response_gen: stub RO PUF, hand-computed responses, timeout and reset cases.
// A background monitor checks challenge stability and clear-cycle spacing around every measurement.
module tb_ro_puf_response_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [5:0] cfg_i;
  logic       busy_o, done_o, error_o, tie_o;
  logic [7:0] response_o;

  int n_cmp  = 0;
  int n_fail = 0;

  ro_puf_response_gen_if pif ();

  ro_puf_response_gen #(.RESP_BITS(8), .TIMEOUT(50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .cfg_i      (cfg_i),
    .puf        (pif),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .response_o (response_o),
    .tie_o      (tie_o)
  );

  always #5 clk = ~clk;

  // Stub PUF: fixed count per RO index, completion on the tm-th enabled cycle.
  int tm        = 10;
  bit never_cmp = 1'b0;
  int en_cnt    = 0;

  function automatic logic [31:0] stub_count(input logic [3:0] idx);
    case (idx)
      4'd0: return 32'd100;
      4'd1: return 32'd90;
      4'd2: return 32'd80;
      4'd3: return 32'd95;
      4'd4: return 32'd70;
      4'd5: return 32'd70;
      4'd6: return 32'd60;
      4'd7: return 32'd50;
      4'd8: return 32'd40;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) en_cnt <= pif.puf_en ? en_cnt + 1 : 0;
  assign pif.puf_count     = stub_count(pif.puf_challenge[9:6]);
  assign pif.puf_completed = pif.puf_en && !never_cmp && (en_cnt == tm - 1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: gap before MEAS_B is the single CLR_B cycle; before the next MEAS_A it is CMP + CLR_A.
  bit         prev_en   = 1'b0;
  logic [9:0] prev_chal = '0;
  int         meas_cnt  = 0;
  int         gap       = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en  = 1'b0;
      meas_cnt = 0;
      gap      = 0;
    end else begin
      if (pif.puf_en) begin
        if (prev_en) begin
          check("chal_stable_en", {22'd0, pif.puf_challenge}, {22'd0, prev_chal});
        end else begin
          check("chal_stable_clr", {22'd0, pif.puf_challenge}, {22'd0, prev_chal});
          if (meas_cnt > 0)
            check("en_low_gap", gap, (meas_cnt % 2 == 1) ? 1 : 2);
          meas_cnt++;
        end
        gap = 0;
      end else begin
        gap++;
      end
      if (!busy_o) begin
        meas_cnt = 0;
        gap      = 0;
      end
      prev_en   = pif.puf_en;
      prev_chal = pif.puf_challenge;
    end
  end

  // One run from a start pulse; optional start+cfg disturbance at cycle poke_at.
  task automatic run(input logic [5:0] c, input int max_cyc, input int poke_at,
                     output int lat, output int ndone, output int badc, output logic e1);
    lat   = -1;
    ndone = 0;
    badc  = 0;
    e1    = 1'bx;
    cfg_i   = c;
    start_i = 1'b1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge clk); #1;
      start_i = (n == poke_at);
      if (n == poke_at) cfg_i = c ^ 6'h3F;
      if (n == 1) e1 = error_o;
      if (done_o) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      if (busy_o && pif.puf_challenge[5:0] !== c) badc++;
    end
    start_i = 1'b0;
  endtask

  // Pairs 100>90,90>80,80<95,95>70,70=70,70>60,60>50,50>40 -> LSB-first 1,1,0,1,0,1,1,1.
  localparam logic [7:0] EXP_RESP = 8'b1110_1011;

  int   lat, nd, bc, dn;
  logic e1;

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    cfg_i   = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     {31'd0, busy_o},       32'd0);
    check("rst_done",     {31'd0, done_o},       32'd0);
    check("rst_error",    {31'd0, error_o},      32'd0);
    check("rst_tie",      {31'd0, tie_o},        32'd0);
    check("rst_response", {24'd0, response_o},   32'd0);
    check("rst_puf_en",   {31'd0, pif.puf_en},   32'd0);
    check("rst_chal",     {22'd0, pif.puf_challenge}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal run with a start+cfg poke mid-run; done is 1+8*23 = 185 edges after the start edge.
    run(6'h2A, 200, 50, lat, nd, bc, e1);
    check("t1_latency",  lat,                  185);
    check("t1_ndone",    nd,                   1);
    check("t1_chal_cfg", bc,                   0);
    check("t1_response", {24'd0, response_o}, {24'd0, EXP_RESP});
    check("t1_tie",      {31'd0, tie_o},      32'd1);
    check("t1_error",    {31'd0, error_o},    32'd0);
    check("t1_busy_end", {31'd0, busy_o},     32'd0);

    // Reset during MEAS_B of bit 3 (edges 82..91 after start).
    cfg_i   = 6'h2A;
    start_i = 1'b1;
    dn      = 0;
    for (int n = 1; n <= 85; n++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (done_o) dn++;
    end
    check("t2_resp_held", {24'd0, response_o},         {24'd0, EXP_RESP});
    check("t2_en_measb",  {31'd0, pif.puf_en},         32'd1);
    check("t2_ro_idx",    {28'd0, pif.puf_challenge[9:6]}, 32'd4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t2_rst_busy",  {31'd0, busy_o},     32'd0);
    check("t2_rst_en",    {31'd0, pif.puf_en}, 32'd0);
    check("t2_rst_resp",  {24'd0, response_o}, 32'd0);
    check("t2_rst_tie",   {31'd0, tie_o},      32'd0);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done_o) dn++;
    end
    check("t2_no_done", dn, 0);

    // PUF never completes: abort after 50 MEAS_A cycles, DONE on edge 1+1+50.
    never_cmp = 1'b1;
    run(6'h07, 80, 0, lat, nd, bc, e1);
    check("t3_latency",  lat,                  52);
    check("t3_ndone",    nd,                   1);
    check("t3_error",    {31'd0, error_o},    32'd1);
    check("t3_response", {24'd0, response_o}, 32'd0);
    check("t3_puf_en",   {31'd0, pif.puf_en}, 32'd0);
    check("t3_busy_end", {31'd0, busy_o},     32'd0);
    never_cmp = 1'b0;

    // Next accepted start clears error immediately; different cfg.
    run(6'h11, 200, 0, lat, nd, bc, e1);
    check("t4_err_clr",  {31'd0, e1},          32'd0);
    check("t4_latency",  lat,                  185);
    check("t4_ndone",    nd,                   1);
    check("t4_chal_cfg", bc,                   0);
    check("t4_response", {24'd0, response_o}, {24'd0, EXP_RESP});
    check("t4_error",    {31'd0, error_o},    32'd0);

    // Completion on the very cycle the timeout is reached wins: 1+8*(2*51+1) = 825.
    tm = 50;
    run(6'h2A, 850, 0, lat, nd, bc, e1);
    check("t5_latency",  lat,                  825);
    check("t5_ndone",    nd,                   1);
    check("t5_error",    {31'd0, error_o},    32'd0);
    check("t5_response", {24'd0, response_o}, {24'd0, EXP_RESP});
    check("t5_tie",      {31'd0, tie_o},      32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
